// File: rtl/muldiv_sequencer_pkg.sv
// Shared constants for the EX-stage multiply/divide unit: op codes,
// FSM state encodings and small op-decoding helpers.
package muldiv_sequencer_pkg;

    // Multiply/divide op codes as presented on the op input
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    // Sequencer states
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

    // MULT and DIV (even codes) treat operands as two's complement
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    // Upper code bit selects the divide family
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             mthi;
    logic             mtlo;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Pipeline side: issues ops and HI/LO moves, watches busy/done and HI/LO
    modport master (
        output start, op, rs_data, rt_data, mthi, mtlo,
        input  busy, done, hi, lo
    );

    // Unit side
    modport slave (
        input  start, op, rs_data, rt_data, mthi, mtlo,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the unsigned core: add-shift for multiply, restoring
// shift-subtract for divide. Purely combinational.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   operand_i,
    input  logic               is_div_i,
    output logic [2*WIDTH-1:0] acc_o
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    // Multiply keeps the carry of the upper-half add in the shifted-in bit.
    // Divide: remainder shifted left with the next dividend bit; the top bit
    // of the WIDTH+1 difference is the borrow, which means "does not fit".
    always_comb begin
        sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, operand_i};
        rem_sh = acc_i[2*WIDTH-1:WIDTH-1];
        diff   = rem_sh - {1'b0, operand_i};
        acc_o  = acc_i;
        if (is_div_i) begin
            if (diff[WIDTH]) begin
                acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
            end else begin
                acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
            end
        end else if (acc_i[0]) begin
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end else begin
            acc_o = {1'b0, acc_i[2*WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit and owner of the HI/LO registers.
// Signed ops run on magnitudes; signs are re-applied in the FIX cycle.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic               clk,
    input logic               reset,
    muldiv_sequencer_if.slave bus
);
    localparam int            CW        = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    md_state_e          state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, done_q;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   opnd_q;
    logic               is_div_q;
    logic               div_zero_q;
    logic               neg_lo_q;
    logic               neg_hi_q;

    logic               accept;
    logic               is_div_in;
    logic               rs_neg, rt_neg;
    logic [WIDTH-1:0]   rs_abs, rt_abs;
    logic [2*WIDTH-1:0] prod_fix;

    assign accept = (state_q == MD_IDLE) && bus.start;

    // Operand magnitudes and sign flags for an incoming op
    always_comb begin
        is_div_in = op_is_div(bus.op);
        rs_neg    = op_is_signed(bus.op) & bus.rs_data[WIDTH-1];
        rt_neg    = op_is_signed(bus.op) & bus.rt_data[WIDTH-1];
        rs_abs    = rs_neg ? (~bus.rs_data + 1'b1) : bus.rs_data;
        rt_abs    = rt_neg ? (~bus.rt_data + 1'b1) : bus.rt_data;
    end

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_i     (acc_q),
        .operand_i (opnd_q),
        .is_div_i  (is_div_q),
        .acc_o     (acc_step)
    );

    // Next-state and iteration counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            MD_IDLE: begin
                if (bus.start) begin
                    state_d = MD_RUN;
                    cnt_d   = '0;
                end
            end
            MD_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = MD_FIX;
                end
            end
            MD_FIX:  state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    // Control registers; busy mirrors the state after this edge, done marks FIX retiring
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d != MD_IDLE);
            done_q  <= (state_q == MD_FIX);
        end
    end

    // Datapath: load magnitudes on accept, then one step per RUN cycle
    always_ff @(posedge clk) begin
        if (accept) begin
            acc_q      <= {{WIDTH{1'b0}}, (is_div_in ? rs_abs : rt_abs)};
            opnd_q     <= is_div_in ? rt_abs : rs_abs;
            is_div_q   <= is_div_in;
            div_zero_q <= (bus.rt_data == '0);
            neg_lo_q   <= rs_neg ^ rt_neg;
            neg_hi_q   <= is_div_in ? rs_neg : (rs_neg ^ rt_neg);
        end else if (state_q == MD_RUN) begin
            acc_q <= acc_step;
        end
    end

    // HI/LO next values: result in FIX, MTHI/MTLO only while idle.
    // A zero divisor leaves the raw all-ones quotient unsigned-corrected.
    always_comb begin
        hi_d     = hi_q;
        lo_d     = lo_q;
        prod_fix = neg_lo_q ? (~acc_q + 1'b1) : acc_q;
        if (state_q == MD_FIX) begin
            if (is_div_q) begin
                if (div_zero_q) begin
                    lo_d = '1;
                end else begin
                    lo_d = neg_lo_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
                end
                hi_d = neg_hi_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
            end else begin
                hi_d = prod_fix[2*WIDTH-1:WIDTH];
                lo_d = prod_fix[WIDTH-1:0];
            end
        end else if (state_q == MD_IDLE) begin
            if (bus.mthi) begin
                hi_d = bus.rs_data;
            end
            if (bus.mtlo) begin
                lo_d = bus.rs_data;
            end
        end
    end

    // Architectural HI/LO registers
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed scenarios plus randomized ops checked
// against an arithmetic reference model.
module tb_muldiv_sequencer;
    import muldiv_sequencer_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    muldiv_sequencer_if #(.WIDTH(32)) bus ();

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: {hi, lo} from plain 64-bit arithmetic
    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] rs,
                                              input logic [31:0] rt);
        longint a, b, q, r;
        logic [63:0] p;
        case (op)
            MD_MULT: begin
                a = longint'($signed(rs));
                b = longint'($signed(rt));
                p = a * b;
                return p;
            end
            MD_MULTU: begin
                p = {32'b0, rs} * {32'b0, rt};
                return p;
            end
            MD_DIV: begin
                if (rt == 32'd0) return {rs, 32'hFFFF_FFFF};
                a = longint'($signed(rs));
                b = longint'($signed(rt));
                q = a / b;
                r = a % b;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (rt == 32'd0) return {rs, 32'hFFFF_FFFF};
                return {rs % rt, rs / rt};
            end
        endcase
    endfunction

    // Issue one op from the post-edge phase; returns result, busy count and done cycle (-1 on timeout)
    task automatic run_op(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          output logic [31:0] got_hi, output logic [31:0] got_lo,
                          output int busy_cyc, output int done_cyc);
        bus.op = op; bus.rs_data = rs; bus.rt_data = rt; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        busy_cyc = 0; done_cyc = -1; got_hi = 'x; got_lo = 'x;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (bus.done) begin
                done_cyc = c; got_hi = bus.hi; got_lo = bus.lo;
                break;
            end
            if (bus.busy) busy_cyc++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
        n_checks++; if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", bus.hi); end
        n_checks++; if (bus.lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", bus.lo); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mult;
        logic [31:0] h, l; int bc, dc;
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, h, l, bc, dc);
        n_checks++; if (h !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_hi: got %h want fffffffe", h); end
        n_checks++; if (l !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_lo: got %h want 00000001", l); end
        n_checks++; if (dc !== 34) begin n_fail++; $display("FAIL multu_latency: got %0d want 34", dc); end
        @(negedge clk);
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL done_pulse: got %b want 0", bus.done); end
        @(posedge clk); #1;
        run_op(MD_MULT, -32'sd3, 32'sd7, h, l, bc, dc);
        n_checks++; if (h !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi: got %h want ffffffff", h); end
        n_checks++; if (l !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mult_lo: got %h want ffffffeb", l); end
        n_checks++; if (bc !== 33) begin n_fail++; $display("FAIL mult_busy_cycles: got %0d want 33", bc); end
    endtask

    task automatic test_div;
        logic [31:0] h, l; int bc, dc;
        run_op(MD_DIV, -32'sd7, 32'sd2, h, l, bc, dc);
        n_checks++; if (l !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg_lo: got %h want fffffffd", l); end
        n_checks++; if (h !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_neg_hi: got %h want ffffffff", h); end
        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, h, l, bc, dc);
        n_checks++; if (l !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf_lo: got %h want 80000000", l); end
        n_checks++; if (h !== 32'h0) begin n_fail++; $display("FAIL div_ovf_hi: got %h want 0", h); end
        run_op(MD_DIV, -32'sd5, 32'd0, h, l, bc, dc);
        n_checks++; if (l !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_zero_lo: got %h want ffffffff", l); end
        n_checks++; if (h !== 32'hFFFF_FFFB) begin n_fail++; $display("FAIL div_zero_hi: got %h want fffffffb", h); end
    endtask

    task automatic test_divzero_ignore_start;
        int dc;
        logic [31:0] h, l;
        dc = -1; h = 'x; l = 'x;
        bus.op = MD_DIVU; bus.rs_data = 32'd100; bus.rt_data = 32'd0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (bus.done) begin dc = c; h = bus.hi; l = bus.lo; break; end
            if (c == 5) begin bus.start = 1'b1; bus.op = MD_MULTU; bus.rs_data = 32'd3; bus.rt_data = 32'd3; end
            if (c == 6) bus.start = 1'b0;
        end
        n_checks++; if (l !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu_zero_lo: got %h want ffffffff", l); end
        n_checks++; if (h !== 32'h0000_0064) begin n_fail++; $display("FAIL divu_zero_hi: got %h want 00000064", h); end
        n_checks++; if (dc !== 34) begin n_fail++; $display("FAIL divu_zero_latency: got %0d want 34", dc); end
        @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL no_queued_start: busy got %b want 0", bus.busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_mthi_mtlo;
        int dc;
        logic [31:0] h, l;
        logic [63:0] exp;
        bus.rs_data = 32'h0BAD_F00D; bus.mthi = 1'b1; bus.mtlo = 1'b1;
        @(posedge clk); #1;
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.hi !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL mt_both_hi: got %h want 0badf00d", bus.hi); end
        n_checks++; if (bus.lo !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL mt_both_lo: got %h want 0badf00d", bus.lo); end
        @(posedge clk); #1;
        bus.rs_data = 32'h1234_5678; bus.mthi = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.hi !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL mthi_before_edge: got %h want 0badf00d", bus.hi); end
        @(posedge clk); #1;
        bus.mthi = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.hi !== 32'h1234_5678) begin n_fail++; $display("FAIL mthi_hi: got %h want 12345678", bus.hi); end
        n_checks++; if (bus.lo !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL mthi_lo_kept: got %h want 0badf00d", bus.lo); end
        @(posedge clk); #1;
        bus.rs_data = 32'h9ABC_DEF0; bus.mtlo = 1'b1;
        @(posedge clk); #1;
        bus.mtlo = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.lo !== 32'h9ABC_DEF0) begin n_fail++; $display("FAIL mtlo_lo: got %h want 9abcdef0", bus.lo); end
        n_checks++; if (bus.hi !== 32'h1234_5678) begin n_fail++; $display("FAIL mtlo_hi_kept: got %h want 12345678", bus.hi); end
        @(posedge clk); #1;
        // mthi together with an accepted start, then mthi while busy
        bus.op = MD_MULTU; bus.rs_data = 32'd5; bus.rt_data = 32'd6; bus.start = 1'b1; bus.mthi = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.mthi = 1'b0;
        dc = -1; h = 'x; l = 'x;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c == 1) begin
                n_checks++; if (bus.hi !== 32'd5) begin n_fail++; $display("FAIL mthi_with_start: got %h want 00000005", bus.hi); end
            end
            if (c == 5) begin
                n_checks++; if (bus.hi !== 32'd5) begin n_fail++; $display("FAIL mthi_while_busy: got %h want 00000005", bus.hi); end
            end
            if (bus.done) begin dc = c; h = bus.hi; l = bus.lo; break; end
            if (c == 3) begin bus.mthi = 1'b1; bus.rs_data = 32'hDEAD_BEEF; end
            if (c == 4) bus.mthi = 1'b0;
        end
        exp = ref_model(MD_MULTU, 32'd5, 32'd6);
        n_checks++; if ({h, l} !== exp) begin n_fail++; $display("FAIL mt_then_result: got %h%h want %h", h, l, exp); end
        n_checks++; if (dc !== 34) begin n_fail++; $display("FAIL mt_then_latency: got %0d want 34", dc); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midop;
        logic [31:0] h, l; int bc, dc;
        bus.op = MD_MULTU; bus.rs_data = 32'hFFFF_FFFF; bus.rt_data = 32'hFFFF_FFFF; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 1; c <= 10; c++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b want 0", bus.done); end
        n_checks++; if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL abort_hi: got %h want 0", bus.hi); end
        n_checks++; if (bus.lo !== 32'h0) begin n_fail++; $display("FAIL abort_lo: got %h want 0", bus.lo); end
        reset = 1'b0;
        @(posedge clk); #1;
        run_op(MD_MULT, -32'sd3, 32'sd7, h, l, bc, dc);
        n_checks++; if ({h, l} !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_fail++; $display("FAIL after_abort_result: got %h%h want ffffffffffffffeb", h, l); end
        n_checks++; if (dc !== 34) begin n_fail++; $display("FAIL after_abort_latency: got %0d want 34", dc); end
    endtask

    task automatic test_random;
        logic [31:0] h, l, rs, rt; logic [1:0] op; int bc, dc; int sel;
        logic [63:0] exp;
        for (int i = 0; i < 40; i++) begin
            op  = 2'($urandom_range(0, 3));
            rs  = $urandom;
            rt  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rt = 32'd0;
            if (sel == 1) rt = 32'($urandom_range(1, 17));
            if (sel == 2) begin rs = 32'h8000_0000; rt = 32'hFFFF_FFFF; end
            if (sel == 3) rs = -32'($urandom_range(1, 1000));
            exp = ref_model(op, rs, rt);
            run_op(op, rs, rt, h, l, bc, dc);
            n_checks++; if (h !== exp[63:32]) begin n_fail++; $display("FAIL rand_hi op=%0d rs=%h rt=%h: got %h want %h", op, rs, rt, h, exp[63:32]); end
            n_checks++; if (l !== exp[31:0]) begin n_fail++; $display("FAIL rand_lo op=%0d rs=%h rt=%h: got %h want %h", op, rs, rt, l, exp[31:0]); end
            n_checks++; if (dc !== 34) begin n_fail++; $display("FAIL rand_latency op=%0d: got %0d want 34", op, dc); end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.op = MD_MULT; bus.rs_data = '0; bus.rt_data = '0;
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_mult();
        test_div();
        test_divzero_ignore_start();
        test_mthi_mtlo();
        test_reset_midop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
